// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
// Optional build macro consumed by the scheduler files: ALU_SCHED_RR_EN.
package alu_sched_pkg;

   // Scheduler FSM states; the encoding is also visible on the debug state port.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } sched_state_e;

   // ALU unit selected by ALU_FUN[3:2].
   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-requester arbiter with one-hot grant.
// ALU_SCHED_RR_EN defined: round-robin, the port that did not win last has
// priority on the next contested cycle. Undefined: fixed priority, port 0 wins
// and no pointer register exists.
module alu_rr_arbiter (
`ifdef ALU_SCHED_RR_EN
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       accept_i,
`endif
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

`ifdef ALU_SCHED_RR_EN
   // Index of the port holding priority on a contested cycle.
   logic ptr_q;
   logic ptr_d;

   // One-hot grant; the pointer only matters when both ports request.
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

   // After a grant to port p, priority moves to the other port.
   always_comb begin
      ptr_d = ptr_q;
      if (accept_i) begin
         ptr_d = gnt_o[0];
      end
   end

   // Pointer register, resets to port 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: port 0 always wins a contest.
   always_comb begin
      gnt_o    = 2'b00;
      gnt_o[0] = req_i[0];
      gnt_o[1] = req_i[1] & ~req_i[0];
   end
`endif

endmodule

// File: rtl/alu_req_scheduler.sv
// Two-port request scheduler sharing one ALU_TOP instance.
// Arbitration mode selected by ALU_SCHED_RR_EN (round-robin when defined,
// fixed priority with port 0 winning otherwise).
//
// Handshakes: a request on port p transfers on the rising edge where
// req_valid[p] & req_ready[p] are both high; a response transfers on the edge
// where rsp_valid & rsp_ready are both high. A valid side holds its payload
// stable until the transfer; ready may be raised or dropped at any time.
module alu_req_scheduler
   import alu_sched_pkg::*;
#(
   parameter int width = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [width-1:0]     req_a0,
   input  logic [width-1:0]     req_b0,
   input  logic [width-1:0]     req_a1,
   input  logic [width-1:0]     req_b1,
   input  logic [3:0]           req_fun0,
   input  logic [3:0]           req_fun1,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [2*width-1:0]   rsp_data,
   output logic                 rsp_flag,
   output logic                 busy,
   output logic [width-1:0]     ALU_A,
   output logic [width-1:0]     ALU_B,
   output logic [3:0]           ALU_FUN,
   input  logic [2*width-1:0]   Arith_Out,
   input  logic [width-1:0]     Logic_Out,
   input  logic [width-1:0]     CMP_Out,
   input  logic [width-1:0]     SHIFT_Out,
   input  logic                 Arith_Flag,
   input  logic                 Logic_Flag,
   input  logic                 CMP_Flag,
   input  logic                 SHIFT_Flag,
   output logic [1:0]           dbg_state_o
);

   sched_state_e         state_q;
   logic [width-1:0]     alu_a_q;
   logic [width-1:0]     alu_b_q;
   logic [3:0]           alu_fun_q;
   logic                 id_q;
   logic                 rsp_valid_q;
   logic                 rsp_id_q;
   logic [2*width-1:0]   rsp_data_q;
   logic                 rsp_flag_q;
   logic                 busy_q;

   logic [1:0]           gnt;
   logic                 accept;
   logic                 win_id;
   logic [width-1:0]     win_a;
   logic [width-1:0]     win_b;
   logic [3:0]           win_fun;

   alu_rr_arbiter u_arb (
`ifdef ALU_SCHED_RR_EN
      .clk_i    (CLK),
      .rst_ni   (RST),
      .accept_i (accept),
`endif
      .req_i    (req_valid),
      .gnt_o    (gnt)
   );

   // Grants are only offered while idle; the winner's payload is muxed for latching.
   always_comb begin
      req_ready = (state_q == IDLE) ? gnt : 2'b00;
      accept    = |(req_valid & req_ready);
      win_id    = req_ready[1];
      win_a     = win_id ? req_a1   : req_a0;
      win_b     = win_id ? req_b1   : req_b0;
      win_fun   = win_id ? req_fun1 : req_fun0;
   end

   // Scheduler FSM: latch request, let the ALU register it, capture the selected
   // unit, then hold the response until it is taken.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_fun_q   <= '0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flag_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  alu_a_q   <= win_a;
                  alu_b_q   <= win_b;
                  alu_fun_q <= win_fun;
                  id_q      <= win_id;
                  busy_q    <= 1'b1;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               // ALU inputs are stable this cycle; its result lands at the edge.
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               case (alu_fun_q[3:2])
                  UNIT_ARITH: begin
                     rsp_data_q <= Arith_Out;
                     rsp_flag_q <= Arith_Flag;
                  end
                  UNIT_LOGIC: begin
                     rsp_data_q <= {{width{1'b0}}, Logic_Out};
                     rsp_flag_q <= Logic_Flag;
                  end
                  UNIT_CMP: begin
                     rsp_data_q <= {{width{1'b0}}, CMP_Out};
                     rsp_flag_q <= CMP_Flag;
                  end
                  default: begin
                     rsp_data_q <= {{width{1'b0}}, SHIFT_Out};
                     rsp_flag_q <= SHIFT_Flag;
                  end
               endcase
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Registered outputs.
   always_comb begin
      ALU_A       = alu_a_q;
      ALU_B       = alu_b_q;
      ALU_FUN     = alu_fun_q;
      rsp_valid   = rsp_valid_q;
      rsp_id      = rsp_id_q;
      rsp_data    = rsp_data_q;
      rsp_flag    = rsp_flag_q;
      busy        = busy_q;
      dbg_state_o = state_q;
   end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler; honours ALU_SCHED_RR_EN when defined.
module tb_alu_req_scheduler;

   localparam int W = 8;
`ifdef ALU_SCHED_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic           CLK = 1'b0;
   logic           RST;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [W-1:0]   req_a0, req_b0, req_a1, req_b1;
   logic [3:0]     req_fun0, req_fun1;
   logic           rsp_valid, rsp_ready, rsp_id, rsp_flag, busy;
   logic [2*W-1:0] rsp_data;
   logic [W-1:0]   ALU_A, ALU_B;
   logic [3:0]     ALU_FUN;
   logic [2*W-1:0] Arith_Out;
   logic [W-1:0]   Logic_Out, CMP_Out, SHIFT_Out;
   logic           Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
   logic [1:0]     dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [17:0] exp_q[$];   // {id, flag, data}
   int rr_prio = 0;         // port holding priority in the reference arbiter

   alu_req_scheduler #(.width(W)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_fun0(req_fun0), .req_fun1(req_fun1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_flag(rsp_flag), .busy(busy),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
      .Arith_Out(Arith_Out), .Logic_Out(Logic_Out), .CMP_Out(CMP_Out),
      .SHIFT_Out(SHIFT_Out), .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
      .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- ALU unit functions ----------------
   function automatic logic [15:0] f_arith(input logic [7:0] a, b, input logic [1:0] op);
      case (op)
         2'd0:    return 16'(a) + 16'(b);
         2'd1:    return 16'(a) - 16'(b);
         2'd2:    return 16'(a) * 16'(b);
         default: return 16'(a) + 16'(b) + 16'd1;
      endcase
   endfunction

   function automatic logic [7:0] f_logic(input logic [7:0] a, b, input logic [1:0] op);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   function automatic logic [7:0] f_cmp(input logic [7:0] a, b, input logic [1:0] op);
      case (op)
         2'd0:    return (a == b) ? 8'd1 : 8'd0;
         2'd1:    return (a > b)  ? 8'd2 : 8'd0;
         2'd2:    return (a < b)  ? 8'd3 : 8'd0;
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic [7:0] f_shift(input logic [7:0] a, b, input logic [1:0] op);
      case (op)
         2'd0:    return a >> 1;
         2'd1:    return a << 1;
         2'd2:    return b >> 1;
         default: return b << 1;
      endcase
   endfunction

   // Expected {flag, data} for a request: result of the unit named by fun[3:2].
   function automatic logic [16:0] ref_rsp(input logic [7:0] a, b, input logic [3:0] f);
      logic [15:0] r;
      logic [7:0]  s;
      logic        fl;
      r = 16'h0; s = 8'h0; fl = 1'b0;
      case (f[3:2])
         2'b00: begin r = f_arith(a, b, f[1:0]); fl = (r[15:8] != 8'h0); end
         2'b01: begin s = f_logic(a, b, f[1:0]); r = {8'h00, s}; fl = ^s; end
         2'b10: begin s = f_cmp(a, b, f[1:0]);   r = {8'h00, s}; fl = (s != 8'h0); end
         default: begin s = f_shift(a, b, f[1:0]); r = {8'h00, s}; fl = s[0]; end
      endcase
      return {fl, r};
   endfunction

   // ALU_TOP stand-in: every unit registers its result each cycle.
   logic [15:0] t_ar;
   logic [7:0]  t_lg, t_cm, t_sh;
   always @(posedge CLK) begin
      t_ar = f_arith(ALU_A, ALU_B, ALU_FUN[1:0]);
      t_lg = f_logic(ALU_A, ALU_B, ALU_FUN[1:0]);
      t_cm = f_cmp(ALU_A, ALU_B, ALU_FUN[1:0]);
      t_sh = f_shift(ALU_A, ALU_B, ALU_FUN[1:0]);
      Arith_Out  <= t_ar;
      Logic_Out  <= t_lg;
      CMP_Out    <= t_cm;
      SHIFT_Out  <= t_sh;
      Arith_Flag <= (t_ar[15:8] != 8'h0);
      Logic_Flag <= ^t_lg;
      CMP_Flag   <= (t_cm != 8'h0);
      SHIFT_Flag <= t_sh[0];
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      check({tag, "_rsp_id"},    32'(rsp_id),    32'h0);
      check({tag, "_rsp_data"},  32'(rsp_data),  32'h0);
      check({tag, "_rsp_flag"},  32'(rsp_flag),  32'h0);
      check({tag, "_busy"},      32'(busy),      32'h0);
      check({tag, "_alu_a"},     32'(ALU_A),     32'h0);
      check({tag, "_alu_b"},     32'(ALU_B),     32'h0);
      check({tag, "_alu_fun"},   32'(ALU_FUN),   32'h0);
      check({tag, "_state"},     32'(dbg_state), 32'h0);
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge; returns at a falling edge with the DUT idle.
   task automatic do_txn(input logic [1:0] v,
                         input logic [7:0] a0, b0, input logic [3:0] f0,
                         input logic [7:0] a1, b1, input logic [3:0] f1,
                         input int stall, input bit keep, output logic got_id);
      int          win;
      int          lat;
      logic [1:0]  g;
      logic [15:0] snap;
      logic [17:0] e;
      req_valid = v;
      req_a0 = a0; req_b0 = b0; req_fun0 = f0;
      req_a1 = a1; req_b1 = b1; req_fun1 = f1;
      rsp_ready = (stall == 0);
      got_id = 1'b0;
      #1;
      if (v == 2'b11) win = RR_EN ? rr_prio : 0;
      else            win = v[1] ? 1 : 0;
      g = (win == 1) ? 2'b10 : 2'b01;
      check("grant", 32'(req_ready), 32'(g));
      check("busy_idle", 32'(busy), 32'h0);
      e = (win == 1) ? {1'b1, ref_rsp(a1, b1, f1)} : {1'b0, ref_rsp(a0, b0, f0)};
      exp_q.push_back(e);
      rr_prio = 1 - win;
      @(posedge CLK);
      @(negedge CLK);
      if (!keep) req_valid = v & ~g;
      #1;
      check("busy_after_accept", 32'(busy), 32'h1);
      check("ready_while_busy", 32'(req_ready), 32'h0);
      lat = 1;
      while (!rsp_valid && lat < 8) begin
         @(negedge CLK); #1;
         lat++;
      end
      check("rsp_latency", 32'(lat), 32'd3);
      e = exp_q.pop_front();
      if (rsp_valid) begin
         snap = rsp_data;
         for (int i = 0; i < stall; i++) begin
            @(negedge CLK); #1;
            check("stall_valid", 32'(rsp_valid), 32'h1);
            check("stall_data", 32'(rsp_data), 32'(snap));
            check("stall_ready", 32'(req_ready), 32'h0);
         end
         rsp_ready = 1'b1;
         got_id = rsp_id;
         check("rsp_id", 32'(rsp_id), 32'(e[17]));
         check("rsp_flag", 32'(rsp_flag), 32'(e[16]));
         check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
         @(posedge CLK);
         @(negedge CLK); #1;
         check("rsp_valid_drop", 32'(rsp_valid), 32'h0);
         check("busy_drop", 32'(busy), 32'h0);
         check("ready_next", 32'(|req_ready), 32'(|req_valid));
      end
   endtask

   // ---------------- stimulus ----------------
   logic       id;
   logic [3:0] ids;

   initial begin
      RST = 1'b0;
      req_valid = 2'b00; rsp_ready = 1'b0;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
      req_fun0 = '0; req_fun1 = '0;
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      rr_prio = 0;
      @(negedge CLK);

      // Port 0 add: 200 + 100.
      do_txn(2'b01, 8'd200, 8'd100, 4'b0000, 8'd0, 8'd0, 4'b0000, 0, 1'b0, id);
      check("add_result_seen", 32'(rsp_data), 32'd300);

      // Port 1 AND: F0 & 3C.
      do_txn(2'b10, 8'd0, 8'd0, 4'b0000, 8'hF0, 8'h3C, 4'b0100, 0, 1'b0, id);
      check("and_result_seen", 32'(rsp_data), 32'h0030);

      // Both ports valid continuously for four operations.
      ids = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         do_txn(2'b11, 8'd10, 8'd3, 4'b0001, 8'd7, 8'd7, 4'b1000, 0, 1'b1, id);
         ids[i] = id;
      end
      check("contested_id_seq", 32'(ids), RR_EN ? 32'b1010 : 32'b0000);
      req_valid = 2'b00;

      // Response stalled for 10 cycles.
      do_txn(2'b01, 8'h81, 8'h02, 4'b1101, 8'd0, 8'd0, 4'b0000, 10, 1'b0, id);

      // Reset during CAPTURE abandons the operation.
      req_valid = 2'b01; req_a0 = 8'd5; req_b0 = 8'd6; req_fun0 = 4'b0010;
      rsp_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      req_valid = 2'b00;
      @(negedge CLK); #1;
      check("state_capture", 32'(dbg_state), 32'd2);
      RST = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(negedge CLK);
      RST = 1'b1;
      rr_prio = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK); #1;
         check("no_rsp_after_reset", 32'(rsp_valid), 32'h0);
      end
      do_txn(2'b10, 8'd0, 8'd0, 4'b0000, 8'd9, 8'd4, 4'b0001, 0, 1'b0, id);

      // Randomized traffic.
      for (int i = 0; i < 24; i++) begin
         do_txn(2'($urandom_range(1, 3)),
                8'($urandom), 8'($urandom), 4'($urandom),
                8'($urandom), 8'($urandom), 4'($urandom),
                $urandom_range(0, 3), 1'b0, id);
      end
      req_valid = 2'b00;
      check("exp_q_empty", 32'(exp_q.size()), 32'h0);

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
